matrix_input_loader: RTL and testbench

Parametrised successor to the matrix input path. It owns its own FSM instead of following an external state code. It accepts dimension and element tokens from the UART decoder, checks them against configurable bounds, and requests a matrix slot from the allocator. It then streams elements into matrix storage in row-major order. New capabilities: an LFSR random-fill mode, early-termination zero padding, and explicit error and done reporting.

---
 rtl/matrix_input_loader_if.sv | 44 ++++
 rtl/matrix_input_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_matrix_input_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_input_loader_if.sv
// Handshake bundle for matrix_input_loader: decoder token stream, slot
// allocation request/grant, and matrix storage write port.
//   master : the loader (drives alloc_req/m/n and write_*)
//   slave  : the surrounding system (drives decoder_*, alloc_valid/fail/id)
interface matrix_input_loader_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DIM_W  = 4,
   parameter int unsigned ID_W   = 7
) ();

   // decoder token stream
   logic              decoder_valid;
   logic [DATA_W-1:0] decoder_data;

   // slot allocation
   logic              alloc_req;
   logic [DIM_W-1:0]  alloc_m;
   logic [DIM_W-1:0]  alloc_n;
   logic              alloc_valid;
   logic              alloc_fail;
   logic [ID_W-1:0]   alloc_id_in;

   // storage write port
   logic              write_en;
   logic [ID_W-1:0]   write_id;
   logic [DIM_W-1:0]  write_row;
   logic [DIM_W-1:0]  write_col;
   logic [DATA_W-1:0] write_data;

   modport master (
      input  decoder_valid, decoder_data,
      input  alloc_valid, alloc_fail, alloc_id_in,
      output alloc_req, alloc_m, alloc_n,
      output write_en, write_id, write_row, write_col, write_data
   );

   modport slave (
      output decoder_valid, decoder_data,
      output alloc_valid, alloc_fail, alloc_id_in,
      input  alloc_req, alloc_m, alloc_n,
      input  write_en, write_id, write_row, write_col, write_data
   );

endinterface

// File: rtl/matrix_input_loader.sv
// Matrix input loader: takes m, n and element tokens from the UART decoder,
// bounds-checks them, requests a storage slot, then writes the elements in
// row-major order. Supports LFSR random fill and early zero padding.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle pulse, begins a load from IDLE
//   rand_mode       sampled at start; 1 = elements generated internally
//   fill_req        pad the remaining elements with zero
//   bus             decoder / allocator / storage handshake (master side)
//   elem_count      elements written so far in the current load
//   busy            FSM not IDLE
//   done            one-cycle pulse when a load completes
//   err_dim         bad dimension or refused allocation, sticky until start
//   err_data        one-cycle pulse per rejected element
module matrix_input_loader #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DIM_W     = 4,
   parameter int unsigned ID_W      = 7,
   parameter int unsigned MAX_DIM   = 5,
   parameter int          ELEM_MIN  = 0,
   parameter int          ELEM_MAX  = 9,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   rand_mode,
   input  logic                   fill_req,
   matrix_input_loader_if.master  bus,
   output logic [2*DIM_W-1:0]     elem_count,
   output logic                   busy,
   output logic                   done,
   output logic                   err_dim,
   output logic                   err_data
);

   localparam int unsigned CNT_W = 2 * DIM_W;
   localparam int unsigned RANGE = unsigned'(ELEM_MAX - ELEM_MIN + 1);
   localparam logic signed [DATA_W-1:0] EMIN = DATA_W'(ELEM_MIN);
   localparam logic signed [DATA_W-1:0] EMAX = DATA_W'(ELEM_MAX);
   // Galois feedback for taps 16,14,13,11 (right-shifting form)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      IDLE, GET_M, GET_N, WAIT_ALLOC, DATA, RAND, FILL, DONE
   } state_t;

   state_t              state_q, state_d;
   logic                rand_q, rand_d;
   logic [DIM_W-1:0]    m_q, m_d, n_q, n_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [DIM_W-1:0]    row_q, row_d, col_q, col_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic                alloc_req_q, alloc_req_d;
   logic [DIM_W-1:0]    alloc_m_q, alloc_m_d, alloc_n_q, alloc_n_d;
   logic                wr_en_q, wr_en_d;
   logic [DIM_W-1:0]    wr_row_q, wr_row_d, wr_col_q, wr_col_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                err_dim_q, err_dim_d, err_data_q, err_data_d;

   logic [CNT_W-1:0]    total_c;
   logic                dim_ok_c, elem_ok_c;
   logic [15:0]         lfsr_mod_c, lfsr_next_c;
   logic [DATA_W-1:0]   rand_val_c;
   logic                wr_fire_c;
   logic [DATA_W-1:0]   wr_val_c;

   // Token qualification and random element generation
   always_comb begin
      total_c    = CNT_W'(m_q) * CNT_W'(n_q);
      dim_ok_c   = (bus.decoder_data >= DATA_W'(1)) &&
                   (bus.decoder_data <= DATA_W'(MAX_DIM));
      elem_ok_c  = ($signed(bus.decoder_data) >= EMIN) &&
                   ($signed(bus.decoder_data) <= EMAX);
      lfsr_mod_c = lfsr_q % 16'(RANGE);
      rand_val_c = DATA_W'(ELEM_MIN) + DATA_W'(lfsr_mod_c);
      lfsr_next_c = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      rand_d      = rand_q;
      m_d         = m_q;
      n_d         = n_q;
      id_d        = id_q;
      row_d       = row_q;
      col_d       = col_q;
      cnt_d       = cnt_q;
      lfsr_d      = lfsr_q;
      alloc_req_d = 1'b0;
      alloc_m_d   = alloc_m_q;
      alloc_n_d   = alloc_n_q;
      wr_en_d     = 1'b0;
      wr_row_d    = wr_row_q;
      wr_col_d    = wr_col_q;
      wr_data_d   = wr_data_q;
      busy_d      = (state_q != IDLE);
      done_d      = (state_q == DONE);
      err_dim_d   = err_dim_q;
      err_data_d  = 1'b0;
      wr_fire_c   = 1'b0;
      wr_val_c    = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = GET_M;
               rand_d    = rand_mode;
               err_dim_d = 1'b0;
               cnt_d     = '0;
               row_d     = '0;
               col_d     = '0;
            end
         end
         GET_M: begin
            if (bus.decoder_valid) begin
               if (dim_ok_c) begin
                  m_d     = bus.decoder_data[DIM_W-1:0];
                  state_d = GET_N;
               end else begin
                  err_dim_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         GET_N: begin
            if (bus.decoder_valid) begin
               if (dim_ok_c) begin
                  n_d         = bus.decoder_data[DIM_W-1:0];
                  alloc_req_d = 1'b1;
                  alloc_m_d   = m_q;
                  alloc_n_d   = bus.decoder_data[DIM_W-1:0];
                  state_d     = WAIT_ALLOC;
               end else begin
                  err_dim_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         WAIT_ALLOC: begin
            // grant takes priority over refusal; tokens are dropped here
            if (bus.alloc_valid) begin
               id_d    = bus.alloc_id_in;
               state_d = rand_q ? RAND : DATA;
            end else if (bus.alloc_fail) begin
               err_dim_d = 1'b1;
               state_d   = IDLE;
            end
         end
         DATA: begin
            if (bus.decoder_valid) begin
               if (elem_ok_c) begin
                  wr_fire_c = 1'b1;
                  wr_val_c  = bus.decoder_data;
               end else begin
                  err_data_d = 1'b1;
               end
            end
            if (fill_req) state_d = FILL;
         end
         RAND: begin
            wr_fire_c = 1'b1;
            wr_val_c  = rand_val_c;
            lfsr_d    = lfsr_next_c;
            if (fill_req) state_d = FILL;
         end
         FILL: begin
            wr_fire_c = 1'b1;
            wr_val_c  = '0;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Shared write path: issue the write, step row-major address, finish
      if (wr_fire_c && (cnt_q < total_c)) begin
         wr_en_d   = 1'b1;
         wr_row_d  = row_q;
         wr_col_d  = col_q;
         wr_data_d = wr_val_c;
         cnt_d     = cnt_q + CNT_W'(1);
         if (col_q == DIM_W'(n_q - DIM_W'(1))) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
         end else begin
            col_d = col_q + DIM_W'(1);
         end
         if (cnt_q + CNT_W'(1) == total_c) state_d = DONE;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rand_q      <= 1'b0;
         m_q         <= '0;
         n_q         <= '0;
         id_q        <= '0;
         row_q       <= '0;
         col_q       <= '0;
         cnt_q       <= '0;
         lfsr_q      <= LFSR_SEED;
         alloc_req_q <= 1'b0;
         alloc_m_q   <= '0;
         alloc_n_q   <= '0;
         wr_en_q     <= 1'b0;
         wr_row_q    <= '0;
         wr_col_q    <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_dim_q   <= 1'b0;
         err_data_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rand_q      <= rand_d;
         m_q         <= m_d;
         n_q         <= n_d;
         id_q        <= id_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cnt_q       <= cnt_d;
         lfsr_q      <= lfsr_d;
         alloc_req_q <= alloc_req_d;
         alloc_m_q   <= alloc_m_d;
         alloc_n_q   <= alloc_n_d;
         wr_en_q     <= wr_en_d;
         wr_row_q    <= wr_row_d;
         wr_col_q    <= wr_col_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_dim_q   <= err_dim_d;
         err_data_q  <= err_data_d;
      end
   end

   assign bus.alloc_req  = alloc_req_q;
   assign bus.alloc_m    = alloc_m_q;
   assign bus.alloc_n    = alloc_n_q;
   assign bus.write_en   = wr_en_q;
   assign bus.write_id   = id_q;
   assign bus.write_row  = wr_row_q;
   assign bus.write_col  = wr_col_q;
   assign bus.write_data = wr_data_q;
   assign elem_count     = cnt_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err_dim        = err_dim_q;
   assign err_data       = err_data_q;

endmodule

// File: tb/tb_matrix_input_loader.sv
// Directed bench for matrix_input_loader. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_matrix_input_loader;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DIM_W  = 4;
   localparam int unsigned ID_W   = 7;
   localparam int unsigned OBS_W  = 1 + ID_W + 2 * DIM_W + DATA_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic rand_mode = 1'b0;
   logic fill_req = 1'b0;
   logic [2*DIM_W-1:0] elem_count;
   logic busy, done, err_dim, err_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   matrix_input_loader_if #(.DATA_W(DATA_W), .DIM_W(DIM_W), .ID_W(ID_W)) bus ();

   matrix_input_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rand_mode  (rand_mode),
      .fill_req   (fill_req),
      .bus        (bus),
      .elem_count (elem_count),
      .busy       (busy),
      .done       (done),
      .err_dim    (err_dim),
      .err_data   (err_data)
   );

   // Observed write port packed as {en, id, row, col, data}
   function automatic logic [OBS_W-1:0] wr_obs();
      return {bus.write_en, bus.write_id, bus.write_row, bus.write_col, bus.write_data};
   endfunction

   function automatic logic [OBS_W-1:0] wr_exp(input int id, input int r, input int c, input int d);
      return {1'b1, 7'(id), 4'(r), 4'(c), 32'(d)};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic token(input logic [31:0] v);
      bus.decoder_valid = 1'b1;
      bus.decoder_data  = v;
      @(negedge clk);
      bus.decoder_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic rm);
      rand_mode = rm;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rand_mode = 1'b0;
   endtask

   task automatic grant(input int id);
      bus.alloc_valid = 1'b1;
      bus.alloc_id_in = 7'(id);
      @(negedge clk);
      bus.alloc_valid = 1'b0;
   endtask

   task automatic setup(input int m, input int n, input int id, input logic rm);
      pulse_start(rm);
      token(32'(m));
      token(32'(n));
      grant(id);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(2);
      checks++; if (bus.write_en !== 1'b0) begin failures++; $display("FAIL reset_write_en got=%b exp=0", bus.write_en); end
      checks++; if (bus.alloc_req !== 1'b0) begin failures++; $display("FAIL reset_alloc_req got=%b exp=0", bus.alloc_req); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (err_dim !== 1'b0 || err_data !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", err_dim, err_data); end
      checks++; if (elem_count !== 8'd0) begin failures++; $display("FAIL reset_elem_count got=%0d exp=0", elem_count); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_manual_2x3();
      pulse_start(1'b0);
      token(32'd2);
      token(32'd3);
      checks++; if ({bus.alloc_req, bus.alloc_m, bus.alloc_n} !== {1'b1, 4'd2, 4'd3}) begin
         failures++; $display("FAIL manual_alloc got=%b/%0d/%0d exp=1/2/3", bus.alloc_req, bus.alloc_m, bus.alloc_n); end
      grant(5);
      checks++; if (bus.alloc_req !== 1'b0) begin failures++; $display("FAIL manual_alloc_pulse got=%b exp=0", bus.alloc_req); end
      for (int i = 0; i < 6; i++) begin
         token(32'(i + 1));
         checks++; if (wr_obs() !== wr_exp(5, i / 3, i % 3, i + 1)) begin
            failures++; $display("FAIL manual_wr%0d got=%h exp=%h", i, wr_obs(), wr_exp(5, i / 3, i % 3, i + 1)); end
         checks++; if (elem_count !== 8'(i + 1)) begin failures++; $display("FAIL manual_cnt%0d got=%0d exp=%0d", i, elem_count, i + 1); end
      end
      tick();
      checks++; if ({done, busy, bus.write_en} !== 3'b110) begin failures++; $display("FAIL manual_done got=%b exp=110", {done, busy, bus.write_en}); end
      tick();
      checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL manual_idle got=%b exp=00", {done, busy}); end
   endtask

   task automatic test_bad_dim();
      pulse_start(1'b0);
      token(32'd6);
      checks++; if (err_dim !== 1'b1) begin failures++; $display("FAIL bad_dim_err got=%b exp=1", err_dim); end
      checks++; if (bus.alloc_req !== 1'b0) begin failures++; $display("FAIL bad_dim_alloc got=%b exp=0", bus.alloc_req); end
      tick(3);
      checks++; if ({busy, err_dim} !== 2'b01) begin failures++; $display("FAIL bad_dim_sticky got=%b exp=01", {busy, err_dim}); end
   endtask

   task automatic test_elem_reject();
      setup(1, 2, 3, 1'b0);
      checks++; if (err_dim !== 1'b0) begin failures++; $display("FAIL reject_err_dim_clear got=%b exp=0", err_dim); end
      token(32'd4);
      checks++; if (wr_obs() !== wr_exp(3, 0, 0, 4)) begin failures++; $display("FAIL reject_wr0 got=%h exp=%h", wr_obs(), wr_exp(3, 0, 0, 4)); end
      token(32'd12);
      checks++; if ({bus.write_en, err_data} !== 2'b01) begin failures++; $display("FAIL reject_12 got=%b exp=01", {bus.write_en, err_data}); end
      token(32'hFFFF_FFFF);
      checks++; if ({bus.write_en, err_data} !== 2'b01) begin failures++; $display("FAIL reject_neg got=%b exp=01", {bus.write_en, err_data}); end
      checks++; if (elem_count !== 8'd1) begin failures++; $display("FAIL reject_cnt_hold got=%0d exp=1", elem_count); end
      token(32'd7);
      checks++; if (wr_obs() !== wr_exp(3, 0, 1, 7)) begin failures++; $display("FAIL reject_wr1 got=%h exp=%h", wr_obs(), wr_exp(3, 0, 1, 7)); end
      checks++; if ({err_data, elem_count} !== {1'b0, 8'd2}) begin failures++; $display("FAIL reject_cnt got=%b/%0d exp=0/2", err_data, elem_count); end
      tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL reject_done got=%b exp=1", done); end
      tick();
   endtask

   task automatic test_fill();
      setup(3, 3, 9, 1'b0);
      token(32'd1);
      token(32'd2);
      checks++; if (wr_obs() !== wr_exp(9, 0, 1, 2)) begin failures++; $display("FAIL fill_wr1 got=%h exp=%h", wr_obs(), wr_exp(9, 0, 1, 2)); end
      fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      checks++; if (bus.write_en !== 1'b0) begin failures++; $display("FAIL fill_req_cycle got=%b exp=0", bus.write_en); end
      for (int i = 2; i < 9; i++) begin
         tick();
         checks++; if (wr_obs() !== wr_exp(9, i / 3, i % 3, 0)) begin
            failures++; $display("FAIL fill_wr%0d got=%h exp=%h", i, wr_obs(), wr_exp(9, i / 3, i % 3, 0)); end
      end
      tick();
      checks++; if ({done, bus.write_en, elem_count} !== {2'b10, 8'd9}) begin
         failures++; $display("FAIL fill_done got=%b/%b/%0d exp=1/0/9", done, bus.write_en, elem_count); end
      tick();
   endtask

   task automatic test_fill_collision();
      setup(2, 2, 4, 1'b0);
      bus.decoder_valid = 1'b1;
      bus.decoder_data  = 32'd5;
      fill_req = 1'b1;
      tick();
      bus.decoder_valid = 1'b0;
      fill_req = 1'b0;
      checks++; if (wr_obs() !== wr_exp(4, 0, 0, 5)) begin failures++; $display("FAIL collide_wr0 got=%h exp=%h", wr_obs(), wr_exp(4, 0, 0, 5)); end
      for (int i = 1; i < 4; i++) begin
         tick();
         checks++; if (wr_obs() !== wr_exp(4, i / 2, i % 2, 0)) begin
            failures++; $display("FAIL collide_wr%0d got=%h exp=%h", i, wr_obs(), wr_exp(4, i / 2, i % 2, 0)); end
      end
      tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL collide_done got=%b exp=1", done); end
      tick();
   endtask

   task automatic test_random();
      logic [15:0] model = 16'hACE1;
      int exp_v;
      setup(2, 2, 1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         exp_v = int'(model % 16'd10);
         tick();
         checks++; if (wr_obs() !== wr_exp(1, i / 2, i % 2, exp_v)) begin
            failures++; $display("FAIL rand_wr%0d got=%h exp=%h", i, wr_obs(), wr_exp(1, i / 2, i % 2, exp_v)); end
         checks++; if (bus.write_data > 32'd9) begin failures++; $display("FAIL rand_range%0d got=%0d exp=0..9", i, bus.write_data); end
         model = model[0] ? ({1'b0, model[15:1]} ^ 16'hB400) : {1'b0, model[15:1]};
      end
      tick();
      checks++; if ({done, elem_count} !== {1'b1, 8'd4}) begin failures++; $display("FAIL rand_done got=%b/%0d exp=1/4", done, elem_count); end
      tick();
   endtask

   task automatic test_alloc();
      pulse_start(1'b0);
      token(32'd2);
      token(32'd2);
      bus.alloc_fail = 1'b1;
      tick();
      bus.alloc_fail = 1'b0;
      checks++; if ({err_dim, bus.write_en} !== 2'b10) begin failures++; $display("FAIL alloc_fail got=%b exp=10", {err_dim, bus.write_en}); end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL alloc_fail_idle got=%b exp=0", busy); end
      // grant and refusal together: grant wins; token before grant is dropped
      pulse_start(1'b0);
      token(32'd1);
      token(32'd1);
      token(32'd8);
      checks++; if (bus.write_en !== 1'b0) begin failures++; $display("FAIL alloc_drop_token got=%b exp=0", bus.write_en); end
      bus.alloc_valid = 1'b1;
      bus.alloc_fail  = 1'b1;
      bus.alloc_id_in = 7'd6;
      tick();
      bus.alloc_valid = 1'b0;
      bus.alloc_fail  = 1'b0;
      checks++; if (err_dim !== 1'b0) begin failures++; $display("FAIL alloc_both_err got=%b exp=0", err_dim); end
      token(32'd3);
      checks++; if (wr_obs() !== wr_exp(6, 0, 0, 3)) begin failures++; $display("FAIL alloc_both_wr got=%h exp=%h", wr_obs(), wr_exp(6, 0, 0, 3)); end
      tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL alloc_both_done got=%b exp=1", done); end
      tick();
   endtask

   task automatic test_reset_mid_load();
      setup(2, 2, 2, 1'b0);
      token(32'd1);
      checks++; if (bus.write_en !== 1'b1) begin failures++; $display("FAIL rstmid_wr got=%b exp=1", bus.write_en); end
      #1 rst = 1'b0;
      #1;
      checks++; if ({bus.write_en, busy, elem_count} !== {2'b00, 8'd0}) begin
         failures++; $display("FAIL rstmid_async got=%b/%b/%0d exp=0/0/0", bus.write_en, busy, elem_count); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      token(32'd4);
      checks++; if ({bus.write_en, busy, elem_count} !== {2'b00, 8'd0}) begin
         failures++; $display("FAIL rstmid_idle got=%b/%b/%0d exp=0/0/0", bus.write_en, busy, elem_count); end
   endtask

   initial begin
      bus.decoder_valid = 1'b0;
      bus.decoder_data  = '0;
      bus.alloc_valid   = 1'b0;
      bus.alloc_fail    = 1'b0;
      bus.alloc_id_in   = '0;
      #1;
      test_reset();
      test_manual_2x3();
      test_bad_dim();
      test_elem_reject();
      test_random();
      test_fill();
      test_fill_collision();
      test_alloc();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
